sm4_round_sequencer: RTL
========================

# sm4_round_sequencer

Iterative SM4 block-cipher engine: accepts one 128-bit block with a mode bit, sequences the single-round SM4 datapath 32 times over a held state register, and returns the word-reversed result. Round keys come from an external, already-expanded round-key store through a same-cycle read port. The block sits between the SM4 register/DMA front end and the key-expansion store, and owns all round counting, key indexing and handshaking.

## Interface
- `UNROLL`, default 1: rounds applied per clock; legal values are 1, 2, 4 and 8. Elaboration fails on any other value.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `clear_i`  in  1  synchronous abort/flush.
- `in_valid_i`  in  1  input block valid.
- `in_ready_o`  out  1  block can accept input.
- `decrypt_i`  in  1  mode: 0 = encrypt, 1 = decrypt. Sampled on accept.
- `data_i`  in  128  input block `{X0,X1,X2,X3}`, with X0 in bits [127:96].
- `rk_idx_o`  out  5*UNROLL  round-key indices. Lane j is at [5j+:5].
- `rk_i`  in  32*UNROLL  round keys returned combinationally for `rk_idx_o`. Lane j is at [32j+:32].
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  result consumed.
- `data_o`  out  128  result block.
- `busy_o`  out  1  high in RUN or DONE.

## Operation
- FSM states are IDLE, RUN and DONE. All are registered; encoding is free.
- **IDLE**
  - `in_ready_o` = 1.
  - When `in_valid_i` is high, the block loads the state register with `data_i`, latches `decrypt_i`, clears the round counter `cnt` (6 bits) and moves to RUN.
- **RUN**
  - Each cycle, UNROLL chained round instances advance the state.
  - Lane j uses `rk_i` lane j.
  - Each round computes `{X1,X2,X3, X0 ^ T(X1^X2^X3^rk)}`.
  - `cnt` increments by UNROLL.
  - When the updated count equals 32, the FSM moves to DONE.
- **Key index, lane j**
  - Encrypt: `cnt+j`.
  - Decrypt: `31-cnt-j`.
  - Width is 5 bits; no wrap can occur.
  - Outside RUN, `rk_idx_o` is driven to 0.
- **DONE**
  - `out_valid_o` = 1.
  - `data_o` is the state reversed: `{X35,X34,X33,X32}`.
  - It is held stable until `out_ready_i`, then the FSM returns to IDLE.
  - `in_ready_o` = 0, so there is no overlap with the next block.
- **`clear_i`**
  - In any state, it forces IDLE on the next edge, zeroes the state register and `cnt`, and drops `out_valid_o`.
  - It takes priority over a same-cycle accept and a same-cycle output handshake.
  - In those cases no block is accepted and no result is delivered.
- **Input changes after accept:** a change to `decrypt_i` or `data_i` after the accept cycle has no effect.
- **`data_o` outside DONE:** it is driven to 0, so no intermediate state is exposed.

## Timing
- **Reset values**
  - `in_ready_o` = 1 (the FSM is in IDLE).
  - `out_valid_o` = 0, `busy_o` = 0, `data_o` = 0, `rk_idx_o` = 0.
  - The state register and `cnt` = 0.
- **Latency:** with the accept edge at cycle 0, RUN occupies cycles 1 to 32/UNROLL, and `out_valid_o` rises in cycle 32/UNROLL + 1.
  - UNROLL=1: 33 cycles.
  - UNROLL=8: 5 cycles.
- **Throughput:** one block per 32/UNROLL + 2 cycles with `out_ready_i` tied high.
- **Output hold:** `out_valid_o` stays high for as long as `out_ready_i` stays low. The output is held indefinitely with no timeout.
- **Key port:** `rk_i` must be valid in the same cycle `rk_idx_o` is presented. The path is combinational through UNROLL rounds and is registered only at the state register.
- **Reset mid-operation:** asynchronous return to the reset values. The block discards the in-flight block and produces no output.

## Structure
- **Package `sm4_pkg`** holds:
  - the `sm4_state_e` FSM enum;
  - `SM4_ROUNDS` = 32;
  - the `sm4_block_t` (128-bit) and `sm4_word_t` (32-bit) typedefs.
- **Round datapath:** a generate loop instantiates the existing single-round combinational module UNROLL times, chained.
- **FSM and counter:** kept in this module. No further sub-module.

## Test plan
- **Encrypt, GB/T 32907 vector.** Key `0123456789abcdeffedcba9876543210`, so rk0 = `f12186f9` and rk31 = `9124a012`. The bench key store holds all 32 rks. Plaintext `0123456789abcdeffedcba9876543210` gives `data_o` = `681edf34d206965e86b3e94f536e4246` at cycle 33 (UNROLL=1).
- **Decrypt, same key.** Input `681edf34d206965e86b3e94f536e4246` with `decrypt_i`=1 returns `0123456789abcdeffedcba9876543210`. `rk_idx_o` must show 31 in the first RUN cycle and 0 in the last.
- **UNROLL=4.** The same encrypt vector completes with `out_valid_o` at cycle 9. Lanes in the first RUN cycle are indices 0, 1, 2, 3.
- **Backpressure.** Hold `out_ready_i`=0 for 10 cycles. `data_o` stays stable, `in_ready_o` stays 0, and `in_valid_i` is ignored. Releasing `out_ready_i` gives IDLE on the next cycle.
- **Clear mid-RUN.** Assert `clear_i` at cycle 10. The block is in IDLE with `data_o`=0 on the next cycle. A following encrypt returns the correct ciphertext.
- **Async reset mid-RUN.** Pulse `rst_ni` low at cycle 15. All outputs take their reset values immediately and `out_valid_o` never asserts for that block.

Source files
------------

// File: rtl/sm4_round_sequencer_pkg.sv
// sm4_pkg: shared types, round count and S-box helpers for the SM4 round sequencer.
package sm4_pkg;
    localparam int SM4_ROUNDS = 32;
    typedef logic [127:0] sm4_block_t;
    typedef logic [31:0] sm4_word_t;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} sm4_state_e;
    // S-box flattened row-major, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[8*(255 - int'(b)) +: 8];
    endfunction
    function automatic sm4_word_t tau(input sm4_word_t a);
        return {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
    endfunction
    function automatic sm4_word_t rotl(input sm4_word_t w, input int n);
        return (w << n) | (w >> (32 - n));
    endfunction
endpackage

// File: rtl/sm4_round_sequencer_if.sv
// sm4_round_sequencer_if: block handshake, result handshake and round-key read port.
interface sm4_round_sequencer_if #(parameter int UNROLL = 1);
    import sm4_pkg::*;
    logic                    clear_i;
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic                    decrypt_i;
    sm4_block_t              data_i;
    logic [5*UNROLL-1:0]     rk_idx_o;
    logic [32*UNROLL-1:0]    rk_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    sm4_block_t              data_o;
    logic                    busy_o;
    modport master (
        output clear_i, in_valid_i, decrypt_i, data_i, rk_i, out_ready_i,
        input  in_ready_o, rk_idx_o, out_valid_o, data_o, busy_o
    );
    modport slave (
        input  clear_i, in_valid_i, decrypt_i, data_i, rk_i, out_ready_i,
        output in_ready_o, rk_idx_o, out_valid_o, data_o, busy_o
    );
endinterface

// File: rtl/sm4_round_sequencer_round.sv
// sm4_round_sequencer_round: one combinational SM4 round, {X1,X2,X3, X0 ^ T(X1^X2^X3^rk)}.
module sm4_round_sequencer_round
    import sm4_pkg::*;
(
    input  sm4_block_t x_i,
    input  sm4_word_t  rk_i,
    output sm4_block_t x_o
);
    sm4_word_t b;
    assign b   = tau(x_i[95:64] ^ x_i[63:32] ^ x_i[31:0] ^ rk_i);
    assign x_o = {x_i[95:0], x_i[127:96] ^ b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24)};
endmodule

// File: rtl/sm4_round_sequencer.sv
// sm4_round_sequencer: iterative SM4 engine applying UNROLL chained rounds per clock to a held state.
module sm4_round_sequencer
    import sm4_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input logic clk_i,
    input logic rst_ni,
    sm4_round_sequencer_if.slave bus
);
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
        $error("sm4_round_sequencer: UNROLL must be 1, 2, 4 or 8");
    end
    sm4_state_e st_q, st_d;
    sm4_block_t state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       dec_q, dec_d, accept, last;
    sm4_block_t chain [UNROLL+1];
    assign chain[0] = state_q;
    for (genvar j = 0; j < UNROLL; j++) begin : g_lane
        logic [4:0] idx;
        sm4_round_sequencer_round u_round (
            .x_i  (chain[j]),
            .rk_i (bus.rk_i[32*j +: 32]),
            .x_o  (chain[j+1])
        );
        // Decrypt walks the schedule backwards: 31-(cnt+j) is the 5-bit complement of cnt+j.
        assign idx = cnt_q[4:0] + 5'(j);
        assign bus.rk_idx_o[5*j +: 5] = (st_q == ST_RUN) ? (dec_q ? ~idx : idx) : '0;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q    <= ST_IDLE;
            state_q <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
        end
    end
    always_comb begin
        accept  = st_q == ST_IDLE && bus.in_valid_i;
        last    = cnt_q + 6'(UNROLL) == 6'(SM4_ROUNDS);
        st_d    = bus.clear_i ? ST_IDLE
                : accept ? ST_RUN
                : (st_q == ST_RUN && last) ? ST_DONE
                : (st_q == ST_DONE && bus.out_ready_i) ? ST_IDLE : st_q;
        state_d = bus.clear_i ? '0 : accept ? bus.data_i : (st_q == ST_RUN) ? chain[UNROLL] : state_q;
        cnt_d   = (bus.clear_i || accept) ? '0 : (st_q == ST_RUN) ? cnt_q + 6'(UNROLL) : cnt_q;
        dec_d   = (accept && !bus.clear_i) ? bus.decrypt_i : dec_q;
    end
    always_comb begin
        bus.in_ready_o  = st_q == ST_IDLE;
        bus.out_valid_o = st_q == ST_DONE;
        bus.busy_o      = st_q != ST_IDLE;
        bus.data_o      = (st_q == ST_DONE) ? {state_q[31:0], state_q[63:32], state_q[95:64], state_q[127:96]} : '0;
    end
endmodule
